// File: rtl/rf_wr_arb.sv
// Write-port arbiter for the 8x16 register file: two one-entry writeback slots
// (A = ALU, B = load) drained oldest-first through the single write port.
module rf_wr_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [2:0]  a_regsel,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [2:0]  b_regsel,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic [2:0]  writeregsel,
  output logic [15:0] writedata,
  output logic        write,
  output logic        err
);

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 16;

  // Holding slots and arbitration state
  logic              pend_a, pend_b;
  logic [SEL_W-1:0]  hsel_a, hsel_b;
  logic [DATA_W-1:0] hdat_a, hdat_b;
  logic              a_first, tie_b;

  // Protocol history: last cycle's stall and request payload per source
  logic              stall_a_q, stall_b_q;
  logic [SEL_W-1:0]  psel_a, psel_b;
  logic [DATA_W-1:0] pdat_a, pdat_b;
  logic              err_q;

  logic grant_a, grant_b, acc_a, acc_b, keep_a, keep_b;
  logic pend_a_n, pend_b_n, a_first_n, tie_b_n, err_n;
  logic viol_a, viol_b;

  // Grant, handshake, write port and next-state computation
  always_comb begin
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    write       = 1'b0;
    writeregsel = '0;
    writedata   = '0;
    a_first_n   = a_first;
    tie_b_n     = tie_b;

    grant_a = ~rst & pend_a & (~pend_b | a_first);
    grant_b = ~rst & pend_b & (~pend_a | ~a_first);
    a_ready = ~rst & (~pend_a | grant_a);
    b_ready = ~rst & (~pend_b | grant_b);
    acc_a   = a_valid & a_ready;
    acc_b   = b_valid & b_ready;

    write = grant_a | grant_b;
    if (grant_a) begin
      writeregsel = hsel_a;
      writedata   = hdat_a;
    end else if (grant_b) begin
      writeregsel = hsel_b;
      writedata   = hdat_b;
    end

    keep_a   = pend_a & ~grant_a;
    keep_b   = pend_b & ~grant_b;
    pend_a_n = acc_a | keep_a;
    pend_b_n = acc_b | keep_b;

    // A surviving entry is always older than a freshly accepted one
    if (pend_a_n & pend_b_n) begin
      if (keep_a) begin
        a_first_n = 1'b1;
      end else if (keep_b) begin
        a_first_n = 1'b0;
      end else begin
        a_first_n = ~tie_b;
        tie_b_n   = ~tie_b;
      end
    end else if (pend_a_n) begin
      a_first_n = 1'b1;
    end else if (pend_b_n) begin
      a_first_n = 1'b0;
    end

    viol_a = stall_a_q & (~a_valid | (a_regsel != psel_a) | (a_data != pdat_a));
    viol_b = stall_b_q & (~b_valid | (b_regsel != psel_b) | (b_data != pdat_b));
    err_n  = err_q | viol_a | viol_b;
    err    = err_q & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      hsel_a    <= '0;
      hsel_b    <= '0;
      hdat_a    <= '0;
      hdat_b    <= '0;
      a_first   <= 1'b0;
      tie_b     <= 1'b0;
      stall_a_q <= 1'b0;
      stall_b_q <= 1'b0;
      psel_a    <= '0;
      psel_b    <= '0;
      pdat_a    <= '0;
      pdat_b    <= '0;
      err_q     <= 1'b0;
    end else begin
      pend_a    <= pend_a_n;
      pend_b    <= pend_b_n;
      if (acc_a) begin
        hsel_a <= a_regsel;
        hdat_a <= a_data;
      end
      if (acc_b) begin
        hsel_b <= b_regsel;
        hdat_b <= b_data;
      end
      a_first   <= a_first_n;
      tie_b     <= tie_b_n;
      stall_a_q <= a_valid & ~a_ready;
      stall_b_q <= b_valid & ~b_ready;
      psel_a    <= a_regsel;
      psel_b    <= b_regsel;
      pdat_a    <= a_data;
      pdat_b    <= b_data;
      err_q     <= err_n;
    end
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed bench for rf_wr_arb: expected writes are queued at drive time and
// popped by a write-port monitor; a register file model checks final contents.
module tb_rf_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [2:0]  a_regsel, b_regsel;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic        write;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  logic [18:0] sb [$];
  logic [15:0] rf [8];

  rf_wr_arb dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_regsel(a_regsel), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_regsel(b_regsel), .b_data(b_data), .b_ready(b_ready),
    .writeregsel(writeregsel), .writedata(writedata), .write(write), .err(err)
  );

  always #5 clk = ~clk;

  // Register file model fed by the write port
  always @(posedge clk) begin
    if (write) rf[writeregsel] <= writedata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write must match the oldest outstanding expected write
  always @(negedge clk) begin
    logic [18:0] e;
    if (write === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'({writeregsel, writedata}), 32'h7ffff);
      end else begin
        e = sb.pop_front();
        check("write_order", 32'({writeregsel, writedata}), 32'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic [2:0] sel, input logic [15:0] dat);
    sb.push_back({sel, dat});
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_regsel = '0; a_data = '0;
    b_valid = 1'b0; b_regsel = '0; b_data = '0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'hdead;
    rst = 1'b1;
    idle_inputs();

    // Reset state
    cyc(); settle();
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_sel", 32'(writeregsel), 32'd0);
    check("rst_data", 32'(writedata), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    cyc();
    rst = 1'b0; settle();
    check("post_rst_a_ready", 32'(a_ready), 32'd1);
    check("post_rst_b_ready", 32'(b_ready), 32'd1);

    // Single write: r3 = 0x1234
    cyc();
    a_valid = 1'b1; a_regsel = 3'd3; a_data = 16'h1234; push(3'd3, 16'h1234);
    settle();
    check("single_a_ready_c1", 32'(a_ready), 32'd1);
    check("single_no_write_c1", 32'(write), 32'd0);
    cyc();
    idle_inputs(); settle();
    check("single_write", 32'(write), 32'd1);
    check("single_sel", 32'(writeregsel), 32'd3);
    check("single_data", 32'(writedata), 32'h1234);
    check("single_a_ready_c2", 32'(a_ready), 32'd1);
    cyc(); settle();
    check("single_rf_r3", 32'(rf[3]), 32'h1234);
    check("single_idle", 32'(write), 32'd0);

    // First tie after reset: A wins, B waits
    a_valid = 1'b1; a_regsel = 3'd1; a_data = 16'haaaa;
    b_valid = 1'b1; b_regsel = 3'd2; b_data = 16'hbbbb;
    push(3'd1, 16'haaaa); push(3'd2, 16'hbbbb);
    settle();
    check("tie1_ready", 32'({a_ready, b_ready}), 32'd3);
    cyc();
    idle_inputs(); settle();
    check("tie1_first_sel", 32'(writeregsel), 32'd1);
    check("tie1_b_ready", 32'(b_ready), 32'd0);
    cyc(); settle();
    check("tie1_second_sel", 32'(writeregsel), 32'd2);
    cyc();

    // Second tie: B wins
    a_valid = 1'b1; a_regsel = 3'd1; a_data = 16'h1111;
    b_valid = 1'b1; b_regsel = 3'd2; b_data = 16'h2222;
    push(3'd2, 16'h2222); push(3'd1, 16'h1111);
    cyc();
    idle_inputs(); settle();
    check("tie2_first_sel", 32'(writeregsel), 32'd2);
    check("tie2_a_ready", 32'(a_ready), 32'd0);
    cyc(); settle();
    check("tie2_second_sel", 32'(writeregsel), 32'd1);
    cyc(); settle();
    check("tie2_rf_r1", 32'(rf[1]), 32'h1111);
    check("tie2_rf_r2", 32'(rf[2]), 32'h2222);

    // Same-register ordering: B then A to r5, youngest value lands last
    b_valid = 1'b1; b_regsel = 3'd5; b_data = 16'h0001; push(3'd5, 16'h0001);
    cyc();
    idle_inputs();
    a_valid = 1'b1; a_regsel = 3'd5; a_data = 16'h0002; push(3'd5, 16'h0002);
    cyc();
    idle_inputs();
    cyc(); cyc(); settle();
    check("same_reg_r5", 32'(rf[5]), 32'h0002);

    // Back-to-back stream from A
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_regsel = 3'(i); a_data = 16'h0100 + 16'(i);
      push(3'(i), 16'h0100 + 16'(i));
      settle();
      check("stream_a_ready", 32'(a_ready), 32'd1);
      if (i > 0) check("stream_write", 32'(write), 32'd1);
      cyc();
    end
    idle_inputs(); settle();
    check("stream_last_write", 32'(write), 32'd1);
    cyc(); cyc(); settle();
    for (int i = 0; i < 8; i++) check("stream_rf", 32'(rf[i]), 32'h0100 + 32'(i));

    // Protocol violation: B changes data while stalled
    a_valid = 1'b1; a_regsel = 3'd0; a_data = 16'ha001;
    b_valid = 1'b1; b_regsel = 3'd7; b_data = 16'h00ff;
    push(3'd0, 16'ha001); push(3'd7, 16'h00ff);
    cyc();
    a_regsel = 3'd1; a_data = 16'ha002; push(3'd1, 16'ha002);
    settle();
    check("viol_b_stalled", 32'(b_ready), 32'd0);
    check("viol_err_before", 32'(err), 32'd0);
    cyc();
    a_valid = 1'b0; b_data = 16'h0f00; push(3'd7, 16'h0f00);
    settle();
    check("viol_b_ready_c3", 32'(b_ready), 32'd1);
    check("viol_err_same_cycle", 32'(err), 32'd0);
    cyc();
    idle_inputs(); settle();
    check("viol_err_set", 32'(err), 32'd1);
    cyc(); settle();
    check("viol_err_sticky1", 32'(err), 32'd1);
    cyc(); settle();
    check("viol_err_sticky2", 32'(err), 32'd1);
    rst = 1'b1; settle();
    check("viol_err_in_rst", 32'(err), 32'd0);
    cyc();
    rst = 1'b0; settle();
    check("viol_err_cleared", 32'(err), 32'd0);

    // Reset mid-operation: both held entries are dropped
    cyc();
    a_valid = 1'b1; a_regsel = 3'd2; a_data = 16'h2bad;
    b_valid = 1'b1; b_regsel = 3'd3; b_data = 16'h3bad;
    cyc();
    idle_inputs(); rst = 1'b1; settle();
    check("midrst_write", 32'(write), 32'd0);
    check("midrst_sel", 32'(writeregsel), 32'd0);
    check("midrst_data", 32'(writedata), 32'd0);
    check("midrst_ready", 32'({a_ready, b_ready}), 32'd0);
    cyc();
    rst = 1'b0; settle();
    check("midrst_after_write", 32'(write), 32'd0);
    check("midrst_after_ready", 32'({a_ready, b_ready}), 32'd3);
    cyc(); settle();
    check("midrst_no_late_write", 32'(write), 32'd0);
    check("midrst_rf_r2", 32'(rf[2]), 32'h0102);
    check("midrst_rf_r3", 32'(rf[3]), 32'h0103);

    cyc();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
